// File: rtl/seg_display_mux_if.sv
// Display-side bus: four digit patterns and enable mask going in,
// multiplexed cathode/anode drive and frame pulse coming out.
`timescale 1ns/1ps
interface seg_display_mux_if;
  logic [7:0] seg0;
  logic [7:0] seg1;
  logic [7:0] seg2;
  logic [7:0] seg3;
  logic [3:0] digit_en;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  // Producer side (game-play stage / bench) drives patterns, observes the display.
  modport master (
    output seg0, seg1, seg2, seg3, digit_en,
    input  seg, an, frame_tick
  );

  // Multiplexer side consumes patterns and drives the display.
  modport slave (
    input  seg0, seg1, seg2, seg3, digit_en,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/seg_display_mux.sv
// Four-digit 7-segment scan multiplexer. Digits are shadowed once per
// frame so a scan never mixes old and new data, every digit slot opens
// with an all-dark window against ghosting, and digit_en masks digits live.
`timescale 1ns/1ps
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 200
) (
  input logic              Clk100M,
  input logic              reset,
  seg_display_mux_if.slave bus
);

  localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [7:0]       r_shadow [4];
  logic             r_load_pending;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_frame_tick;

  logic [7:0]       w_seg_in [4];
  logic [3:0]       w_sel;
  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_in_blank;
  logic [7:0]       w_seg_next;
  logic [3:0]       w_an_next;

  assign w_seg_in[0] = bus.seg0;
  assign w_seg_in[1] = bus.seg1;
  assign w_seg_in[2] = bus.seg2;
  assign w_seg_in[3] = bus.seg3;

  // One-hot decode of the digit currently being scanned.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      assign w_sel[gi] = (r_idx == 2'(gi));
    end
  endgenerate

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);
  assign w_in_blank  = (r_cnt < CNT_BLANK);

  // Next display drive: dark during the blank window or for a masked digit,
  // otherwise the shadowed pattern of the current digit with its anode low.
  always_comb begin
    w_an_next  = 4'hF;
    w_seg_next = 8'hFF;
    if (!w_in_blank && bus.digit_en[r_idx]) begin
      w_an_next  = ~w_sel;
      w_seg_next = r_shadow[r_idx];
    end
  end

  // Scan counters, frame-coherent shadow capture and registered outputs.
  always_ff @(posedge Clk100M) begin
    if (reset) begin
      r_cnt          <= '0;
      r_idx          <= 2'd0;
      r_load_pending <= 1'b1;
      r_seg          <= 8'hFF;
      r_an           <= 4'hF;
      r_frame_tick   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= 8'hFF;
      end
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Shadow loads right after reset (so the first frame is not blank)
      // and then only at frame boundaries.
      if (r_load_pending || w_frame_end) begin
        for (int i = 0; i < 4; i++) begin
          r_shadow[i] <= w_seg_in[i];
        end
      end
      r_load_pending <= 1'b0;

      r_frame_tick <= w_frame_end;
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux with REFRESH_DIV=8, BLANK_CYCLES=2. A cycle-position
// model predicts the display every cycle; directed checks pin literal values.
`timescale 1ns/1ps
module tb_seg_display_mux;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seg_display_mux_if bus();

  seg_display_mux #(
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .Clk100M(clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: position in cycles since reset released, frame shadow.
  int         m_pos = 0;
  logic [7:0] m_shadow [4];
  logic       m_pending = 1'b1;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_tick;
  logic       exp_valid = 1'b0;

  function automatic logic [1:0] slot_of(int p);
    return 2'((p / DIV) % 4);
  endfunction

  function automatic logic [3:0] lit_anodes(logic [1:0] s);
    logic [3:0] a;
    a    = 4'hF;
    a[s] = 1'b0;
    return a;
  endfunction

  function automatic logic an_legal(logic [3:0] a);
    return (a == 4'hF) || (a == 4'hE) || (a == 4'hD) || (a == 4'hB) || (a == 4'h7);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", name, got, want, m_pos);
    end
  endtask

  // Model: what the display must show in the next cycle, from the position
  // inside the frame, the live enable mask and the frame-captured digits.
  always @(posedge clk) begin
    exp_valid <= 1'b1;
    if (reset) begin
      m_pos     <= 0;
      m_pending <= 1'b1;
      exp_seg   <= 8'hFF;
      exp_an    <= 4'hF;
      exp_tick  <= 1'b0;
      for (int i = 0; i < 4; i++) m_shadow[i] <= 8'hFF;
    end else begin
      if ((m_pos % DIV) < BLANK || bus.digit_en[slot_of(m_pos)] == 1'b0) begin
        exp_an  <= 4'hF;
        exp_seg <= 8'hFF;
      end else begin
        exp_an  <= lit_anodes(slot_of(m_pos));
        exp_seg <= m_shadow[slot_of(m_pos)];
      end
      exp_tick <= ((m_pos % FRAME) == FRAME - 1);
      if (m_pending || (m_pos % FRAME) == FRAME - 1) begin
        m_shadow[0] <= bus.seg0;
        m_shadow[1] <= bus.seg1;
        m_shadow[2] <= bus.seg2;
        m_shadow[3] <= bus.seg3;
      end
      m_pending <= 1'b0;
      m_pos     <= m_pos + 1;
    end
  end

  // Every-cycle comparison against the model plus display-safety invariants.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("model_seg", 32'(bus.seg), 32'(exp_seg));
      check("model_an", 32'(bus.an), 32'(exp_an));
      check("model_tick", 32'(bus.frame_tick), 32'(exp_tick));
      check("an_onehot", 32'(an_legal(bus.an)), 32'd1);
      check("seg_dark_when_off", 32'((bus.an != 4'hF) || (bus.seg == 8'hFF)), 32'd1);
    end
  end

  task automatic wait_pos(input int k);
    int budget;
    budget = 0;
    while (m_pos != k && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (m_pos != k) check("wait_pos_timeout", 32'(m_pos), 32'(k));
  endtask

  task automatic wait_tick(output int p);
    p = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        p = m_pos;
        break;
      end
    end
  endtask

  task automatic check_disp(input string name, input logic [3:0] an_w, input logic [7:0] seg_w);
    check({name, "_an"}, 32'(bus.an), 32'(an_w));
    check({name, "_seg"}, 32'(bus.seg), 32'(seg_w));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    bus.seg0     = 8'hC0;
    bus.seg1     = 8'hF9;
    bus.seg2     = 8'hA4;
    bus.seg3     = 8'hB0;
    bus.digit_en = 4'hF;
    reset        = 1'b1;

    // Reset held for three cycles: display stays dark.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_disp("in_reset", 4'hF, 8'hFF);
      check("in_reset_tick", 32'(bus.frame_tick), 32'd0);
    end
    reset = 1'b0;

    // Scan order and blank windows of the first frame.
    check_disp("p0", 4'hF, 8'hFF);
    wait_pos(2);  check_disp("p2_blank", 4'hF, 8'hFF);
    wait_pos(3);  check_disp("p3_d0", 4'hE, 8'hC0);
    wait_pos(8);  check_disp("p8_d0", 4'hE, 8'hC0);
    wait_pos(9);  check_disp("p9_blank", 4'hF, 8'hFF);
    wait_pos(11); check_disp("p11_d1", 4'hD, 8'hF9);
    wait_pos(19); check_disp("p19_d2", 4'hB, 8'hA4);
    wait_pos(27); check_disp("p27_d3", 4'h7, 8'hB0);
    wait_pos(31); check("p31_tick", 32'(bus.frame_tick), 32'd0);
    wait_pos(32); check("p32_tick", 32'(bus.frame_tick), 32'd1);
    check_disp("p32_d3", 4'h7, 8'hB0);
    wait_pos(33); check("p33_tick", 32'(bus.frame_tick), 32'd0);
    check_disp("p33_blank", 4'hF, 8'hFF);

    // Mid-frame change to digit 1 stays hidden until the frame boundary.
    wait_pos(44); bus.seg1 = 8'h99;
    wait_pos(46); check_disp("coh_old", 4'hD, 8'hF9);
    wait_tick(p); check("tick_2nd_pos", 32'(p), 32'd64);
    wait_pos(65); check("tick_width", 32'(bus.frame_tick), 32'd0);
    wait_pos(75); check_disp("coh_new", 4'hD, 8'h99);
    wait_pos(80); bus.seg1 = 8'h92;
    wait_pos(82); bus.seg1 = 8'h99;
    wait_tick(p); check("tick_3rd_pos", 32'(p), 32'd96);
    wait_pos(107); check_disp("glitch_hidden", 4'hD, 8'h99);

    // Enable mask: digits 0 and 2 dark, then digit 3 cleared mid-slot.
    wait_pos(127); bus.digit_en = 4'b1010;
    wait_pos(131); check_disp("mask_d0", 4'hF, 8'hFF);
    wait_pos(136); check_disp("mask_d0_end", 4'hF, 8'hFF);
    wait_pos(139); check_disp("mask_d1", 4'hD, 8'h99);
    wait_pos(147); check_disp("mask_d2", 4'hF, 8'hFF);
    wait_pos(155); check_disp("mask_d3", 4'h7, 8'hB0);
    wait_pos(157); check_disp("mask_d3_before", 4'h7, 8'hB0);
    bus.digit_en = 4'b0010;
    wait_pos(158); check_disp("mask_d3_cleared", 4'hF, 8'hFF);

    // One-cycle reset at idx 2, cnt 5; new seg0 must appear without a frame end.
    wait_pos(160); bus.digit_en = 4'hF;
    wait_pos(170); bus.seg0 = 8'h88;
    wait_pos(181); reset = 1'b1;
    @(negedge clk);
    check_disp("mid_reset", 4'hF, 8'hFF);
    check("mid_reset_pos", 32'(m_pos), 32'd0);
    reset = 1'b0;
    wait_pos(2); check_disp("post_rst_blank", 4'hF, 8'hFF);
    wait_pos(3); check_disp("post_rst_reload", 4'hE, 8'h88);
    wait_tick(p); check("post_rst_tick_pos", 32'(p), 32'd32);

    // Random patterns and masks; model and invariants checked every cycle.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      bus.seg0     = 8'($urandom);
      bus.seg1     = 8'($urandom);
      bus.seg2     = 8'($urandom);
      bus.seg3     = 8'($urandom);
      bus.digit_en = 4'($urandom);
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Downstream of the game-play stage: consumes the four per-digit segment patterns (seg0..seg3) and time-multiplexes them onto the board's shared 7-segment bus (seg) and anode enables (an).
- Captures a shadow copy of all four digits once per scan frame so a digit never shows a mix of old and new data.
- Adds an anti-ghosting blank window after each digit switch and a per-digit enable mask.

Parameters:
- REFRESH_DIV, 100000: Clk100M cycles per digit slot; 1 kHz digit rate, 250 Hz frame. Legal range is ≥ 4.
- BLANK_CYCLES, 200: cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV.

Ports:
- Clk100M  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- seg0  input  8  digit 0 (rightmost) pattern, active-low segments, bit7 = dp.
- seg1  input  8  digit 1 pattern.
- seg2  input  8  digit 2 pattern.
- seg3  input  8  digit 3 (leftmost) pattern.
- digit_en  input  4  per-digit enable; bit i = 0 keeps digit i dark.
- seg  output  8  shared cathode bus, active-low.
- an  output  4  anode enables, active-low, one-hot-low when lit.
- frame_tick  output  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Clocking: one clock (Clk100M); reset is synchronous and active-high. All state and all outputs are registered on Clk100M.
- Reset values: cnt=0, idx=0, shadow0..3=8'hFF, load_pending=1, seg=8'hFF, an=4'hF, frame_tick=0.
- Reset held for any cycle mid-scan forces the reset values on the next edge. Scanning restarts at digit 0 with a full blank window.
- Prescaler cnt:
  - counts 0..REFRESH_DIV-1;
  - at REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0, wrapping 3→0 with no extra cycle.
- Frame end is the cycle with idx==3 and cnt==REFRESH_DIV-1:
  - frame_tick=1 on the following edge, for exactly one cycle;
  - shadow0..3 <= seg0..seg3 on that same edge.
- load_pending:
  - on the first non-reset cycle after reset, shadow0..3 <= seg0..seg3 and load_pending clears;
  - otherwise shadow loads only at frame end;
  - input changes at any other time are invisible until the next frame end.
- Output function, registered with 1-cycle latency from the current (idx, cnt):
  - cnt < BLANK_CYCLES: an=4'hF, seg=8'hFF.
  - else if digit_en[idx]==0: an=4'hF, seg=8'hFF.
  - else: an = ~(4'b0001 << idx), seg = shadow[idx].
- digit_en is sampled live each cycle, not shadowed. Clearing a bit mid-slot darkens that digit on the next edge.
- Lit time per digit per frame is REFRESH_DIV − BLANK_CYCLES cycles. At most one an bit is ever low.
- seg is 8'hFF whenever an==4'hF, so no cathode drive occurs while all anodes are off.
- A frame is 4·REFRESH_DIV cycles. frame_tick period is exactly 4·REFRESH_DIV after the first one.
- The first frame after reset has the same timing as every later frame: frame_tick fires 4·REFRESH_DIV cycles after reset deasserts.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset and scan order: hold reset 3 cycles with seg0..3=8'hC0,8'hF9,8'hA4,8'hB0 and digit_en=4'hF.
   - Every cycle during reset: seg=FF, an=F.
   - After release, each 8-cycle slot: 2 cycles an=F, then 6 cycles of an=E/seg=C0, then D/F9, then B/A4, then 7/B0, repeating.
2. frame_tick cadence: count cycles between pulses.
   - First pulse 32 cycles after reset deasserts; every later one exactly 32 apart; each pulse 1 cycle wide.
3. Shadow coherence:
   - Change seg1 to 8'h99 while idx==1 is lit: an=D still shows F9 for the rest of that frame.
   - After the next frame_tick: digit 1 shows 99.
   - Change seg1 to 8'h92 and back to 8'h99 within one frame, not at frame end: the glitch value 92 never appears on seg.
4. digit_en mask:
   - digit_en=4'b1010: slots 0 and 2 show an=F, seg=FF for all 8 cycles; slots 1 and 3 light normally.
   - Clear bit 3 mid-slot 3: an=F from the next edge onward.
5. Reset mid-operation: assert reset for 1 cycle while idx==2, cnt==5.
   - Next cycle seg=FF, an=F.
   - Scan restarts at digit 0 with blank cycles.
   - Shadow reloads from current inputs on the first post-reset cycle.
   - frame_tick comes 32 cycles after release.
6. One-hot invariant: random seg*/digit_en stimulus for 10k cycles; assertion checks:
   - an ∈ {F, E, D, B, 7};
   - seg==FF whenever an==F.
